// File: rtl/w_full.sv
// Write-side pointer, full/almost-full flags and occupancy for an async FIFO.
// Brings the read-domain Gray pointer across with two flops and compares it against the next write pointer.
module w_full #(
    parameter int ADDR_W    = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   r_ptr_async,
    input  logic              w_en,
    input  logic              clear_ovf,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_ack,
    output logic [ADDR_W:0]   w_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_count,
    output logic              overflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_C   = PTR_W'(1 << ADDR_W);
    localparam logic [PTR_W-1:0] AF_C      = PTR_W'(AF_MARGIN);
    // Full means equal to the read pointer with the two top Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PTR_W-1:0] rq1_q, rq2_q;
    logic [PTR_W-1:0] w_bin_q, w_bin_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] r_bin_s;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             w_ack_s;

    assign w_ack_s     = w_en & ~full_q;
    assign w_ack       = w_ack_s;
    assign w_addr      = w_bin_q[ADDR_W-1:0];
    assign w_ptr       = w_ptr_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign w_count     = count_q;
    assign overflow    = ovf_q;

    // Next pointer, flags and occupancy from the synchronised read pointer.
    always_comb begin
        r_bin_s = gray2bin(rq2_q);
        w_bin_d = w_bin_q + {{ADDR_W{1'b0}}, w_ack_s};
        w_ptr_d = bin2gray(w_bin_d);
        full_d  = (w_ptr_d == (rq2_q ^ FULL_MASK));
        count_d = w_bin_d - r_bin_s;
        af_d    = ((DEPTH_C - count_d) <= AF_C);
        if (w_en && full_q) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Synchroniser and write-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq1_q   <= {PTR_W{1'b0}};
            rq2_q   <= {PTR_W{1'b0}};
            w_bin_q <= {PTR_W{1'b0}};
            w_ptr_q <= {PTR_W{1'b0}};
            count_q <= {PTR_W{1'b0}};
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rq1_q   <= r_ptr_async;
            rq2_q   <= rq1_q;
            w_bin_q <= w_bin_d;
            w_ptr_q <= w_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_w_full.sv
// Directed bench for w_full: expected pointer/flag states are queued when a step is driven
// and compared after the following clock edge.
module tb_w_full;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] r_ptr_async;
    logic       w_en, clear_ovf;
    logic [2:0] w_addr;
    logic       w_ack, full, almost_full, overflow;
    logic [3:0] w_ptr, w_count;

    logic [3:0] r_ptr2;
    logic       w_en2, clear_ovf2;
    logic [2:0] w_addr2;
    logic       w_ack2, full2, af2, ovf2;
    logic [3:0] w_ptr2, w_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] ptr;
        logic [3:0] cnt;
        logic       full;
        logic       af;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    w_full #(.ADDR_W(3), .AF_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .r_ptr_async(r_ptr_async), .w_en(w_en),
        .clear_ovf(clear_ovf), .w_addr(w_addr), .w_ack(w_ack), .w_ptr(w_ptr),
        .full(full), .almost_full(almost_full), .w_count(w_count), .overflow(overflow)
    );

    w_full #(.ADDR_W(3), .AF_MARGIN(4)) dut_af4 (
        .clk(clk), .rst(rst), .r_ptr_async(r_ptr2), .w_en(w_en2),
        .clear_ovf(clear_ovf2), .w_addr(w_addr2), .w_ack(w_ack2), .w_ptr(w_ptr2),
        .full(full2), .almost_full(af2), .w_count(w_count2), .overflow(ovf2)
    );

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int ptr, input int cnt, input logic f, input logic a);
        exp_t e;
        e.tag = tag; e.ptr = 4'(ptr); e.cnt = 4'(cnt); e.full = f; e.af = a;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_ptr"},  32'(w_ptr),       32'(e.ptr));
            chk({e.tag, "_cnt"},  32'(w_count),     32'(e.cnt));
            chk({e.tag, "_full"}, 32'(full),        32'(e.full));
            chk({e.tag, "_af"},   32'(almost_full), 32'(e.af));
        end
    endtask

    initial begin
        rst = 1'b0; r_ptr_async = 4'd0; w_en = 1'b0; clear_ovf = 1'b0;
        r_ptr2 = 4'd0; w_en2 = 1'b0; clear_ovf2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset asserted mid-stream while writing
        w_en = 1'b1;
        tick();
        tick();
        chk("pre_reset_ptr", 32'(w_ptr), 32'(gray(2)));
        #2 rst = 1'b0;
        #1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_cnt", 32'(w_count), 32'd0);
        chk("rst_ptr", 32'(w_ptr), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(w_addr), 32'd0);
        w_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();

        // Fill 8 entries with the read pointer parked at 0
        for (int i = 1; i <= 8; i++) begin
            w_en = 1'b1;
            #1;
            chk("fill_addr", 32'(w_addr), 32'(i - 1));
            chk("fill_ack", 32'(w_ack), 32'd1);
            push("fill", int'(gray(i)), i, (i == 8), (i >= 6));
            tick();
            pop_cmp();
        end

        // Writes while full are refused and flagged
        for (int i = 0; i < 2; i++) begin
            w_en = 1'b1;
            #1;
            chk("ovf_ack", 32'(w_ack), 32'd0);
            push("ovf", 12, 8, 1'b1, 1'b1);
            tick();
            pop_cmp();
            chk("ovf_set", 32'(overflow), 32'd1);
        end
        clear_ovf = 1'b1; w_en = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        w_en = 1'b0;
        tick();
        chk("ovf_clear", 32'(overflow), 32'd0);
        clear_ovf = 1'b0;

        // Read pointer advances by one: visible three edges later
        r_ptr_async = gray(1);
        push("rd_e1", 12, 8, 1'b1, 1'b1);
        push("rd_e2", 12, 8, 1'b1, 1'b1);
        push("rd_e3", 12, 7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            pop_cmp();
        end

        // Streaming with the synchronised read pointer four entries behind, across the wrap
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r_ptr_async = gray((n == 0) ? 0 : ((n - 1) % 16));
            w_en = 1'b1;
            push("stream", int'(gray((n + 1) % 16)), (n + 1 < 4) ? (n + 1) : 4, 1'b0, 1'b0);
            #1;
            chk("stream_ack", 32'(w_ack), 32'd1);
            tick();
            pop_cmp();
        end
        w_en = 1'b0;

        // AF_MARGIN=4 instance: almost_full at four entries
        for (int k = 1; k <= 4; k++) begin
            w_en2 = 1'b1;
            tick();
            chk("af4_cnt", 32'(w_count2), 32'(k));
            chk("af4_af", 32'(af2), 32'(k >= 4));
            chk("af4_full", 32'(full2), 32'd0);
        end
        w_en2 = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
